// File: rtl/xbar_pkg.sv
// rtl/xbar_pkg.sv - shared types, helper function and default sizes for cross_bar_nxm
//
// Purpose : slave-port FSM state type, a clog2 that never returns 0, and index widths
//           for the default 4x4 configuration.
// Ports   : none (package)
package xbar_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      RESP = 2'd2
   } slv_state_t;

   // Index width for a vector of n entries; a 1-entry index still needs one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_N_MASTERS = 4;
   localparam int DEF_N_SLAVES  = 4;
   localparam int MST_IDX_W     = clog2_min1(DEF_N_MASTERS);
   localparam int SLV_IDX_W     = clog2_min1(DEF_N_SLAVES);

endpackage

// File: rtl/cross_bar_nxm_if.sv
// rtl/cross_bar_nxm_if.sv - master-side and slave-side bus bundle of the N x M crossbar
//
// Purpose : groups every per-master and per-slave signal as flat vectors.
// Modports: slave  - the crossbar's view (takes master requests, drives slave requests)
//           master - the environment's view (bus masters and slave devices)
// Signals : m_req/m_addr/m_cmd/m_wdata -> m_ack/m_resp/m_rdata/m_err
//           s_req/s_addr/s_cmd/s_wdata -> s_ack/s_resp/s_rdata
interface cross_bar_nxm_if #(
   parameter int N_MASTERS = 4,
   parameter int N_SLAVES  = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
);
   logic [N_MASTERS-1:0]        m_req;
   logic [N_MASTERS*ADDR_W-1:0] m_addr;
   logic [N_MASTERS-1:0]        m_cmd;
   logic [N_MASTERS*DATA_W-1:0] m_wdata;
   logic [N_MASTERS-1:0]        m_ack;
   logic [N_MASTERS-1:0]        m_resp;
   logic [N_MASTERS*DATA_W-1:0] m_rdata;
   logic [N_MASTERS-1:0]        m_err;

   logic [N_SLAVES-1:0]         s_req;
   logic [N_SLAVES*ADDR_W-1:0]  s_addr;
   logic [N_SLAVES-1:0]         s_cmd;
   logic [N_SLAVES*DATA_W-1:0]  s_wdata;
   logic [N_SLAVES-1:0]         s_ack;
   logic [N_SLAVES-1:0]         s_resp;
   logic [N_SLAVES*DATA_W-1:0]  s_rdata;

   modport slave (
      input  m_req, m_addr, m_cmd, m_wdata, s_ack, s_resp, s_rdata,
      output m_ack, m_resp, m_rdata, m_err, s_req, s_addr, s_cmd, s_wdata
   );

   modport master (
      output m_req, m_addr, m_cmd, m_wdata, s_ack, s_resp, s_rdata,
      input  m_ack, m_resp, m_rdata, m_err, s_req, s_addr, s_cmd, s_wdata
   );
endinterface

// File: rtl/xbar_slave_port.sv
// rtl/xbar_slave_port.sv - one slave port: address filter, round-robin arbiter, lock FSM
//
// Purpose : picks one master whose address decodes to SLV_ID, holds the grant through
//           the address and read-response phases, and reports ack/resp per master.
// Inputs  : clk, rst, m_req/m_addr/m_cmd/m_wdata (all masters), s_ack/s_resp/s_rdata
// Outputs : s_req/s_addr/s_cmd/s_wdata, ack_vec/resp_vec (one-hot on owner),
//           rdata (zero unless a response fires), err
// Option  : XBAR_RESP_TIMEOUT_EN adds a response watchdog of TIMEOUT_CYCLES.
module xbar_slave_port
   import xbar_pkg::*;
#(
   parameter int N_MASTERS      = 4,
   parameter int N_SLAVES       = 4,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int SLV_ID         = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_MASTERS-1:0]        m_req,
   input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
   input  logic [N_MASTERS-1:0]        m_cmd,
   input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
   output logic                        s_req,
   output logic [ADDR_W-1:0]           s_addr,
   output logic                        s_cmd,
   output logic [DATA_W-1:0]           s_wdata,
   input  logic                        s_ack,
   input  logic                        s_resp,
   input  logic [DATA_W-1:0]           s_rdata,
   output logic [N_MASTERS-1:0]        ack_vec,
   output logic [N_MASTERS-1:0]        resp_vec,
   output logic [DATA_W-1:0]           rdata,
   output logic                        err
);

   localparam int MW = clog2_min1(N_MASTERS);
   localparam int SW = $clog2(N_SLAVES);

   slv_state_t             state;
   logic [MW-1:0]          grant;
   logic [MW-1:0]          ptr;
   logic [MW-1:0]          pick;
   logic [MW-1:0]          idx;
   logic [N_MASTERS-1:0]   hit;
   logic [N_MASTERS-1:0]   gnt_oh;
   logic [ADDR_W-1:0]      addr_a  [N_MASTERS];
   logic [DATA_W-1:0]      wdata_a [N_MASTERS];
   logic                   g_req, g_cmd, in_addr, ack_fire, resp_fire, timeout_fire;

   always_comb begin
      hit = '0;
      for (int m = 0; m < N_MASTERS; m++) begin
         addr_a[m]  = m_addr[m*ADDR_W +: ADDR_W];
         wdata_a[m] = m_wdata[m*DATA_W +: DATA_W];
         hit[m]     = m_req[m] && (m_addr[m*ADDR_W+ADDR_W-1 -: SW] == SW'(SLV_ID));
      end
   end

   // Scan from the farthest candidate down to ptr+1 so the nearest requester wins.
   always_comb begin
      pick = '0;
      idx  = '0;
      for (int i = N_MASTERS; i >= 1; i--) begin
         idx = MW'((int'(ptr) + i) % N_MASTERS);
         if (hit[idx]) pick = idx;
      end
   end

   assign g_req    = m_req[grant];
   assign g_cmd    = m_cmd[grant];
   assign gnt_oh   = N_MASTERS'(1) << grant;
   assign in_addr  = (state == ADDR) && g_req;
   assign s_req    = in_addr;
   assign s_cmd    = in_addr && g_cmd;
   assign s_addr   = in_addr ? addr_a[grant]  : '0;
   assign s_wdata  = in_addr ? wdata_a[grant] : '0;
   assign ack_fire = in_addr && s_ack;

   // A zero-wait read completes in the ack cycle; otherwise the response comes in RESP.
   assign resp_fire = (ack_fire && !g_cmd && s_resp) || ((state == RESP) && s_resp) || timeout_fire;

   assign ack_vec  = ack_fire  ? gnt_oh : '0;
   assign resp_vec = resp_fire ? gnt_oh : '0;
   assign rdata    = (resp_fire && !timeout_fire) ? s_rdata : '0;
   assign err      = timeout_fire;

`ifdef XBAR_RESP_TIMEOUT_EN
   localparam int CW = clog2_min1(TIMEOUT_CYCLES);
   logic [CW-1:0] cnt;

   // Held at zero outside RESP, so it starts from zero on every entry into RESP.
   always_ff @(posedge clk) begin
      if (rst || state != RESP) cnt <= '0;
      else                      cnt <= cnt + CW'(1);
   end

   assign timeout_fire = (state == RESP) && !s_resp && (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
   assign timeout_fire   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         ptr   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|hit) begin
                  grant <= pick;
                  state <= ADDR;
               end
            end
            ADDR: begin
               if (!g_req) begin
                  state <= IDLE;             // abandoned request: fairness pointer untouched
               end else if (s_ack) begin
                  if (g_cmd || s_resp) begin
                     state <= IDLE;
                     ptr   <= grant;
                  end else begin
                     state <= RESP;
                  end
               end
            end
            RESP: begin
               if (resp_fire) begin
                  state <= IDLE;
                  ptr   <= grant;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/cross_bar_nxm.sv
// rtl/cross_bar_nxm.sv - parametrised N-master x M-slave crossbar with locked grants
//
// Purpose : decodes the top address bits to a slave, arbitrates each slave port
//           round-robin, and routes ack/read responses back to the owning master.
// Ports   : clk, rst (synchronous, active high), bus (cross_bar_nxm_if.slave)
// Option  : define XBAR_RESP_TIMEOUT_EN to enable the per-slave response watchdog
//           (TIMEOUT_CYCLES); otherwise m_err is constant 0.
module cross_bar_nxm
   import xbar_pkg::*;
#(
   parameter int N_MASTERS      = DEF_N_MASTERS,
   parameter int N_SLAVES       = DEF_N_SLAVES,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic            clk,
   input  logic            rst,
   cross_bar_nxm_if.slave  bus
);

   logic                 s_req_v   [N_SLAVES];
   logic [ADDR_W-1:0]    s_addr_v  [N_SLAVES];
   logic                 s_cmd_v   [N_SLAVES];
   logic [DATA_W-1:0]    s_wdata_v [N_SLAVES];
   logic [N_MASTERS-1:0] ack_v     [N_SLAVES];
   logic [N_MASTERS-1:0] resp_v    [N_SLAVES];
   logic [DATA_W-1:0]    rdata_v   [N_SLAVES];
   logic                 err_v     [N_SLAVES];

   logic [N_SLAVES-1:0]         s_req_f, s_cmd_f;
   logic [N_SLAVES*ADDR_W-1:0]  s_addr_f;
   logic [N_SLAVES*DATA_W-1:0]  s_wdata_f;
   logic [N_MASTERS-1:0]        m_ack_f, m_resp_f, m_err_f;
   logic [N_MASTERS*DATA_W-1:0] m_rdata_f;

   for (genvar s = 0; s < N_SLAVES; s++) begin : g_port
      xbar_slave_port #(
         .N_MASTERS      (N_MASTERS),
         .N_SLAVES       (N_SLAVES),
         .ADDR_W         (ADDR_W),
         .DATA_W         (DATA_W),
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
         .SLV_ID         (s)
      ) u_port (
         .clk      (clk),
         .rst      (rst),
         .m_req    (bus.m_req),
         .m_addr   (bus.m_addr),
         .m_cmd    (bus.m_cmd),
         .m_wdata  (bus.m_wdata),
         .s_req    (s_req_v[s]),
         .s_addr   (s_addr_v[s]),
         .s_cmd    (s_cmd_v[s]),
         .s_wdata  (s_wdata_v[s]),
         .s_ack    (bus.s_ack[s]),
         .s_resp   (bus.s_resp[s]),
         .s_rdata  (bus.s_rdata[s*DATA_W +: DATA_W]),
         .ack_vec  (ack_v[s]),
         .resp_vec (resp_v[s]),
         .rdata    (rdata_v[s]),
         .err      (err_v[s])
      );
   end

   // A master is owned by at most one slave port, so a plain OR acts as the return mux.
   always_comb begin
      s_req_f   = '0;
      s_cmd_f   = '0;
      s_addr_f  = '0;
      s_wdata_f = '0;
      m_ack_f   = '0;
      m_resp_f  = '0;
      m_err_f   = '0;
      m_rdata_f = '0;
      for (int s = 0; s < N_SLAVES; s++) begin
         s_req_f[s]                      = s_req_v[s];
         s_cmd_f[s]                      = s_cmd_v[s];
         s_addr_f[s*ADDR_W +: ADDR_W]    = s_addr_v[s];
         s_wdata_f[s*DATA_W +: DATA_W]   = s_wdata_v[s];
         m_ack_f                         = m_ack_f  | ack_v[s];
         m_resp_f                        = m_resp_f | resp_v[s];
         m_err_f                         = m_err_f  | (err_v[s] ? resp_v[s] : '0);
         for (int m = 0; m < N_MASTERS; m++) begin
            if (resp_v[s][m])
               m_rdata_f[m*DATA_W +: DATA_W] = m_rdata_f[m*DATA_W +: DATA_W] | rdata_v[s];
         end
      end
   end

   assign bus.s_req   = s_req_f;
   assign bus.s_cmd   = s_cmd_f;
   assign bus.s_addr  = s_addr_f;
   assign bus.s_wdata = s_wdata_f;
   assign bus.m_ack   = m_ack_f;
   assign bus.m_resp  = m_resp_f;
   assign bus.m_err   = m_err_f;
   assign bus.m_rdata = m_rdata_f;

endmodule

// File: tb/tb_cross_bar_nxm.sv
// tb/tb_cross_bar_nxm.sv - directed self-checking bench for cross_bar_nxm (4x4, TIMEOUT_CYCLES=8)
module tb_cross_bar_nxm;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   cross_bar_nxm_if #(.N_MASTERS(4), .N_SLAVES(4), .ADDR_W(32), .DATA_W(32)) bus ();

   cross_bar_nxm #(
      .N_MASTERS(4), .N_SLAVES(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1, "watchdog");
   end

   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic drive_m(input int m, input logic req, input logic [31:0] addr,
                          input logic cmd, input logic [31:0] wd);
      bus.m_req[m]            = req;
      bus.m_addr[m*32 +: 32]  = addr;
      bus.m_cmd[m]            = cmd;
      bus.m_wdata[m*32 +: 32] = wd;
   endtask

   task automatic drive_s(input int s, input logic ack, input logic resp, input logic [31:0] rd);
      bus.s_ack[s]            = ack;
      bus.s_resp[s]           = resp;
      bus.s_rdata[s*32 +: 32] = rd;
   endtask

   task automatic clear_all();
      bus.m_req = '0; bus.m_addr = '0; bus.m_cmd = '0; bus.m_wdata = '0;
      bus.s_ack = '0; bus.s_resp = '0; bus.s_rdata = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_all();
      repeat (3) next_cycle();
      #1;
      vectors++; if ({bus.s_req, bus.m_ack, bus.m_resp, bus.m_err, bus.s_cmd} !== 20'h0) begin
         $display("FAIL reset_flags: got %h want 00000", {bus.s_req, bus.m_ack, bus.m_resp, bus.m_err, bus.s_cmd}); miscompares++; end
      vectors++; if ({bus.s_addr, bus.s_wdata, bus.m_rdata} !== '0) begin
         $display("FAIL reset_data: got %h want 0", {bus.s_addr, bus.s_wdata, bus.m_rdata}); miscompares++; end
      next_cycle(); rst = 1'b0;
      next_cycle(); #1;
      vectors++; if (bus.s_req !== 4'b0000) begin
         $display("FAIL idle_sreq: got %b want 0000", bus.s_req); miscompares++; end
      next_cycle(); drive_m(0, 1'b1, 32'h4000_0000, 1'b1, 32'h0000_A5A5); #1;
      vectors++; if (bus.s_req !== 4'b0000) begin
         $display("FAIL first_req_same_cycle: got %b want 0000", bus.s_req); miscompares++; end
      next_cycle(); #1;
      vectors++; if (bus.s_req !== 4'b0010) begin
         $display("FAIL first_req_latency: got %b want 0010", bus.s_req); miscompares++; end
      vectors++; if (bus.s_addr[32 +: 32] !== 32'h4000_0000 || bus.s_wdata[32 +: 32] !== 32'h0000_A5A5) begin
         $display("FAIL first_req_fwd: got %h/%h want 40000000/0000a5a5", bus.s_addr[32 +: 32], bus.s_wdata[32 +: 32]); miscompares++; end
      drive_s(1, 1'b1, 1'b0, 32'h0); #1;
      vectors++; if (bus.m_ack !== 4'b0001) begin
         $display("FAIL first_ack: got %b want 0001", bus.m_ack); miscompares++; end
      next_cycle(); clear_all(); #1;
      vectors++; if (bus.s_req !== 4'b0000 || bus.m_ack !== 4'b0000) begin
         $display("FAIL first_done: got %b/%b want 0000/0000", bus.s_req, bus.m_ack); miscompares++; end
   endtask

   task automatic test_contention();
      logic [3:0] exp_ack;
      int         order [5];
      order = '{1, 2, 3, 0, 1};
      next_cycle();
      for (int m = 0; m < 4; m++) drive_m(m, 1'b1, 32'h8000_0000 | m, 1'b1, 32'h100 + m);
      drive_s(2, 1'b1, 1'b0, 32'h0); #1;
      vectors++; if (bus.s_req !== 4'b0000) begin
         $display("FAIL cont_no_early_req: got %b want 0000", bus.s_req); miscompares++; end
      for (int k = 0; k < 5; k++) begin
         exp_ack = 4'b0001 << order[k];
         next_cycle(); #1;
         vectors++; if (bus.m_ack !== exp_ack || bus.s_wdata[64 +: 32] !== 32'h100 + order[k]) begin
            $display("FAIL cont_grant%0d: got ack %b wdata %h want ack %b wdata %h", k, bus.m_ack,
                     bus.s_wdata[64 +: 32], exp_ack, 32'h100 + order[k]); miscompares++; end
         next_cycle(); #1;
         vectors++; if (bus.m_ack !== 4'b0000 || bus.s_req !== 4'b0000) begin
            $display("FAIL cont_gap%0d: got ack %b sreq %b want 0000/0000", k, bus.m_ack, bus.s_req); miscompares++; end
      end
      next_cycle(); clear_all(); #1;
      vectors++; if (bus.m_ack !== 4'b0000 || bus.s_req !== 4'b0000) begin
         $display("FAIL cont_drop: got ack %b sreq %b want 0000/0000", bus.m_ack, bus.s_req); miscompares++; end
      next_cycle();
   endtask

   task automatic test_read_lock();
      next_cycle(); drive_m(0, 1'b1, 32'h0000_0010, 1'b0, 32'h0); #1;
      next_cycle(); drive_m(1, 1'b1, 32'h0000_0020, 1'b0, 32'h0); drive_s(0, 1'b1, 1'b0, 32'h0); #1;
      vectors++; if (bus.m_ack !== 4'b0001 || bus.s_addr[0 +: 32] !== 32'h0000_0010) begin
         $display("FAIL lock_m0_ack: got %b/%h want 0001/00000010", bus.m_ack, bus.s_addr[0 +: 32]); miscompares++; end
      for (int k = 1; k <= 4; k++) begin
         next_cycle();
         if (k == 1) drive_m(0, 1'b0, 32'h0, 1'b0, 32'h0);
         drive_s(0, 1'b0, 1'b0, 32'h0); #1;
         vectors++; if (bus.m_ack !== 4'b0000 || bus.s_req !== 4'b0000 || bus.m_resp !== 4'b0000) begin
            $display("FAIL lock_hold_t%0d: got ack %b sreq %b resp %b want 0000", k, bus.m_ack, bus.s_req, bus.m_resp); miscompares++; end
      end
      next_cycle(); drive_s(0, 1'b0, 1'b1, 32'hDEAD_BEEF); #1;
      vectors++; if (bus.m_resp !== 4'b0001 || bus.m_rdata[0 +: 32] !== 32'hDEAD_BEEF || bus.m_ack !== 4'b0000) begin
         $display("FAIL lock_resp: got resp %b rdata %h ack %b want 0001/deadbeef/0000", bus.m_resp, bus.m_rdata[0 +: 32], bus.m_ack); miscompares++; end
      next_cycle(); drive_s(0, 1'b0, 1'b0, 32'h0); #1;
      vectors++; if (bus.m_ack !== 4'b0000 || bus.m_resp !== 4'b0000) begin
         $display("FAIL lock_t6: got ack %b resp %b want 0000/0000", bus.m_ack, bus.m_resp); miscompares++; end
      next_cycle(); drive_s(0, 1'b1, 1'b0, 32'h0); #1;
      vectors++; if (bus.m_ack !== 4'b0010 || bus.s_addr[0 +: 32] !== 32'h0000_0020) begin
         $display("FAIL lock_m1_ack: got %b/%h want 0010/00000020", bus.m_ack, bus.s_addr[0 +: 32]); miscompares++; end
      next_cycle(); drive_m(1, 1'b0, 32'h0, 1'b0, 32'h0); drive_s(0, 1'b0, 1'b1, 32'h0000_0055); #1;
      vectors++; if (bus.m_resp !== 4'b0010 || bus.m_rdata[32 +: 32] !== 32'h0000_0055) begin
         $display("FAIL lock_m1_resp: got %b/%h want 0010/00000055", bus.m_resp, bus.m_rdata[32 +: 32]); miscompares++; end
      next_cycle(); clear_all();
   endtask

   task automatic test_parallel();
      next_cycle();
      drive_m(0, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0077);
      drive_m(1, 1'b1, 32'hC000_0000, 1'b0, 32'h0); #1;
      next_cycle(); drive_s(0, 1'b1, 1'b0, 32'h0); #1;
      vectors++; if (bus.s_req !== 4'b1001 || bus.m_ack !== 4'b0001 || bus.s_addr[96 +: 32] !== 32'hC000_0000) begin
         $display("FAIL par_both_req: got sreq %b ack %b addr3 %h want 1001/0001/c0000000", bus.s_req, bus.m_ack, bus.s_addr[96 +: 32]); miscompares++; end
      next_cycle(); drive_m(0, 1'b0, 32'h0, 1'b0, 32'h0); drive_s(0, 1'b0, 1'b0, 32'h0); drive_s(3, 1'b1, 1'b0, 32'h0); #1;
      vectors++; if (bus.s_req !== 4'b1000 || bus.m_ack !== 4'b0010) begin
         $display("FAIL par_s3_ack: got sreq %b ack %b want 1000/0010", bus.s_req, bus.m_ack); miscompares++; end
      next_cycle(); drive_m(1, 1'b0, 32'h0, 1'b0, 32'h0); drive_s(3, 1'b0, 1'b1, 32'hCAFE_0003); #1;
      vectors++; if (bus.m_resp !== 4'b0010 || bus.m_rdata[32 +: 32] !== 32'hCAFE_0003 || bus.m_err !== 4'b0000) begin
         $display("FAIL par_s3_resp: got %b/%h/%b want 0010/cafe0003/0000", bus.m_resp, bus.m_rdata[32 +: 32], bus.m_err); miscompares++; end
      next_cycle(); clear_all(); #1;
      vectors++; if (bus.m_resp !== 4'b0000 || bus.s_req !== 4'b0000) begin
         $display("FAIL par_idle: got resp %b sreq %b want 0000/0000", bus.m_resp, bus.s_req); miscompares++; end
   endtask

   task automatic test_zero_wait_reset();
      next_cycle(); drive_m(2, 1'b1, 32'h4000_0004, 1'b0, 32'h0); #1;
      next_cycle(); drive_s(1, 1'b1, 1'b1, 32'h0BAD_F00D); #1;
      vectors++; if (bus.m_ack !== 4'b0100 || bus.m_resp !== 4'b0100 || bus.m_rdata[64 +: 32] !== 32'h0BAD_F00D) begin
         $display("FAIL zw_resp: got ack %b resp %b rdata %h want 0100/0100/0badf00d", bus.m_ack, bus.m_resp, bus.m_rdata[64 +: 32]); miscompares++; end
      next_cycle(); drive_m(2, 1'b0, 32'h0, 1'b0, 32'h0); drive_s(1, 1'b0, 1'b0, 32'h0);
      drive_m(3, 1'b1, 32'h4000_0008, 1'b0, 32'h0); #1;
      next_cycle(); #1;
      vectors++; if (bus.s_req !== 4'b0010 || bus.s_addr[32 +: 32] !== 32'h4000_0008) begin
         $display("FAIL zw_back_to_idle: got %b/%h want 0010/40000008", bus.s_req, bus.s_addr[32 +: 32]); miscompares++; end
      drive_s(1, 1'b1, 1'b0, 32'h0); #1;
      next_cycle(); drive_m(3, 1'b0, 32'h0, 1'b0, 32'h0); drive_s(1, 1'b0, 1'b0, 32'h0); rst = 1'b1; #1;
      next_cycle(); rst = 1'b0; drive_s(1, 1'b0, 1'b1, 32'h0000_1111); #1;
      vectors++; if (bus.m_resp !== 4'b0000 || bus.m_rdata !== '0) begin
         $display("FAIL rst_drops_resp: got %b/%h want 0000/0", bus.m_resp, bus.m_rdata); miscompares++; end
      next_cycle(); drive_s(1, 1'b0, 1'b0, 32'h0);
      for (int m = 0; m < 4; m++) drive_m(m, 1'b1, 32'h4000_0000, 1'b1, 32'h200 + m); #1;
      next_cycle(); drive_s(1, 1'b1, 1'b0, 32'h0); #1;
      vectors++; if (bus.m_ack !== 4'b0010 || bus.s_wdata[32 +: 32] !== 32'h0000_0201) begin
         $display("FAIL rst_ptr_zero: got ack %b wdata %h want 0010/00000201", bus.m_ack, bus.s_wdata[32 +: 32]); miscompares++; end
      next_cycle(); clear_all(); #1;
      next_cycle();
   endtask

   task automatic test_timeout();
      next_cycle(); drive_m(1, 1'b1, 32'hC000_0010, 1'b0, 32'h0); #1;
      next_cycle(); drive_s(3, 1'b1, 1'b0, 32'hFFFF_FFFF); #1;
      vectors++; if (bus.m_ack !== 4'b0010) begin
         $display("FAIL to_ack: got %b want 0010", bus.m_ack); miscompares++; end
`ifdef XBAR_RESP_TIMEOUT_EN
      for (int k = 1; k <= 7; k++) begin
         next_cycle();
         if (k == 1) begin drive_m(1, 1'b0, 32'h0, 1'b0, 32'h0); drive_s(3, 1'b0, 1'b0, 32'hFFFF_FFFF); end
         #1;
         vectors++; if (bus.m_resp !== 4'b0000 || bus.m_err !== 4'b0000) begin
            $display("FAIL to_wait_t%0d: got resp %b err %b want 0000/0000", k, bus.m_resp, bus.m_err); miscompares++; end
      end
      next_cycle(); #1;
      vectors++; if (bus.m_resp !== 4'b0010 || bus.m_err !== 4'b0010 || bus.m_rdata[32 +: 32] !== 32'h0) begin
         $display("FAIL to_fire: got resp %b err %b rdata %h want 0010/0010/0", bus.m_resp, bus.m_err, bus.m_rdata[32 +: 32]); miscompares++; end
      next_cycle(); drive_s(3, 1'b0, 1'b1, 32'h0000_1234); #1;
      vectors++; if (bus.m_resp !== 4'b0000 || bus.m_err !== 4'b0000) begin
         $display("FAIL to_late_resp: got resp %b err %b want 0000/0000", bus.m_resp, bus.m_err); miscompares++; end
`else
      for (int k = 1; k <= 20; k++) begin
         next_cycle();
         if (k == 1) begin drive_m(1, 1'b0, 32'h0, 1'b0, 32'h0); drive_s(3, 1'b0, 1'b0, 32'hFFFF_FFFF); end
         #1;
         vectors++; if (bus.m_resp !== 4'b0000 || bus.m_err !== 4'b0000) begin
            $display("FAIL noto_wait_t%0d: got resp %b err %b want 0000/0000", k, bus.m_resp, bus.m_err); miscompares++; end
      end
      next_cycle(); drive_s(3, 1'b0, 1'b1, 32'h1234_5678); #1;
      vectors++; if (bus.m_resp !== 4'b0010 || bus.m_err !== 4'b0000 || bus.m_rdata[32 +: 32] !== 32'h1234_5678) begin
         $display("FAIL noto_resp: got resp %b err %b rdata %h want 0010/0000/12345678", bus.m_resp, bus.m_err, bus.m_rdata[32 +: 32]); miscompares++; end
`endif
      next_cycle(); clear_all(); #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      clear_all();
      test_reset();
      test_contention();
      test_read_lock();
      test_parallel();
      test_zero_wait_reset();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cross_bar_nxm.md
Name: cross_bar_nxm

Overview:
- Parametrised N-master x M-slave crossbar; the next generation of the fixed 4x4 crossbar.
- Sits between bus masters and memory-mapped slaves.
- Slave selection comes from the top address bits. Each slave port has its own round-robin arbiter.
- Each grant is locked for the whole transaction, including the read-response phase; responses are routed back to the owning master.

Parameters:
- N_MASTERS, 4, number of master ports (>=2)
- N_SLAVES, 4, number of slave ports (power of two, >=2)
- ADDR_W, 32, address width; slave index = addr[ADDR_W-1 -: $clog2(N_SLAVES)]
- DATA_W, 32, read/write data width
- TIMEOUT_CYCLES, 256, response watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- m_req  in  N_MASTERS  per-master request
- m_addr  in  N_MASTERS*ADDR_W  per-master address
- m_cmd  in  N_MASTERS  1=write, 0=read
- m_wdata  in  N_MASTERS*DATA_W  write data
- m_ack  out  N_MASTERS  request accepted
- m_resp  out  N_MASTERS  read data valid
- m_rdata  out  N_MASTERS*DATA_W  read data
- m_err  out  N_MASTERS  error flag, valid with m_resp (tied 0 without the optional feature)
- s_req  out  N_SLAVES  request to slave
- s_addr  out  N_SLAVES*ADDR_W  forwarded address
- s_cmd  out  N_SLAVES  forwarded command
- s_wdata  out  N_SLAVES*DATA_W  forwarded write data
- s_ack  in  N_SLAVES  slave accepted
- s_resp  in  N_SLAVES  slave read data valid
- s_rdata  in  N_SLAVES*DATA_W  slave read data

Behaviour:
- Reset (rst=1 at a clk edge): all FSMs go to IDLE and all RR pointers to 0.
  - All s_req/m_ack/m_resp/m_err are 0 and s_addr/s_wdata/m_rdata are 0.
  - Reset mid-transaction drops it silently; no ack or resp is emitted afterwards.
- Master protocol: m_req, m_addr, m_cmd and m_wdata stay stable from assertion until the cycle m_ack=1.
- Per-slave FSM:
  - IDLE:
    - Sample the requests decoded to this slave.
    - The RR arbiter picks the first requester at or after ptr+1, modulo N_MASTERS.
    - Register the grant index and move to ADDR. Grant is registered, so s_req rises 1 cycle after m_req.
  - ADDR:
    - s_req=1; s_addr/s_cmd/s_wdata are driven combinationally from the granted master.
    - s_ack is passed combinationally to that master's m_ack.
    - On s_ack with a write: go to IDLE and set ptr=grant.
    - On s_ack with a read: go to RESP, unless s_resp=1 in the same cycle, in which case resp is forwarded and the FSM goes to IDLE.
    - If the granted m_req drops before ack, go to IDLE without updating ptr.
  - RESP:
    - s_req=0; wait for s_resp, then forward s_rdata/s_resp to the granted master in the same cycle.
    - Go to IDLE and set ptr=grant.
- Lock: while a slave FSM is not IDLE, other requesters for that slave are held (no ack).
- Independent slaves operate concurrently; a master has at most one outstanding transaction.
- Master output mux: at most one slave FSM owns a given master at a time.
  - m_ack/m_resp/m_rdata are the OR of the owning slave's signals, masked by grant.
- A request raised in the same cycle as a response to that master is arbitrated next cycle in IDLE.
- Minimum back-to-back rate for one slave: 1 transaction per 2 cycles (IDLE->ADDR->IDLE).

Optional Feature:
- Macro XBAR_RESP_TIMEOUT_EN.
- Defined:
  - Per-slave counter clears on entry to RESP and increments each RESP cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 without s_resp, pulse m_resp=1, m_err=1, m_rdata=0 to the owner, then go to IDLE and set ptr=grant.
  - A late s_resp in IDLE is ignored.
- Not defined: no counter; RESP waits indefinitely; m_err is constant 0.

Decomposition:
- Package xbar_pkg holds:
  - slave-FSM state enum {IDLE, ADDR, RESP}
  - function clog2_min1
  - localparam helpers SLV_IDX_W, MST_IDX_W
- Sub-module xbar_slave_port contains one slave's decode-filtered request vector, RR arbiter, FSM and optional watchdog. The top instantiates N_SLAVES of them and builds the request matrix and master-side muxes.

Test Plan:
- Reset/idle: rst=1 for 3 cycles, then m_req=0 -> all outputs 0; m_req[0]=1, addr=0x4000_0000 -> s_req[1]=1 exactly 1 cycle later.
- Contention: masters 0,1,2,3 all write slave 2 continuously, s_ack immediate -> grants in order 1,2,3,0,1,... (ptr starts at 0); each m_ack arrives exactly once.
- Read lock: M0 reads slave 0, s_ack at t, s_resp at t+5 with rdata=0xDEAD_BEEF -> M1's concurrent request to slave 0 is not acked before t+6; M0 gets m_rdata=0xDEAD_BEEF at t+5.
- Parallel: M0->S0 and M1->S3 raised in the same cycle -> both s_req assert in the same cycle and both complete independently.
- Zero-wait read plus reset: s_ack and s_resp in the same cycle -> FSM returns to IDLE. Separately, rst=1 while in RESP -> no m_resp follows, and the next request is arbitrated from ptr=0.
- Timeout (XBAR_RESP_TIMEOUT_EN, TIMEOUT_CYCLES=8): read with no s_resp -> m_resp=1, m_err=1, m_rdata=0 eight cycles after ack; without the macro, m_err stays 0 forever.
